// File: rtl/alu_bist_ctrl_if.sv
// Stimulus/response bus between the BIST controller (master) and the 4-bit ALU under test (slave).
interface alu_bist_ctrl_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_slt;
  logic       alu_zero;

  modport master (output alu_a, alu_b, alu_op, input alu_result, alu_slt, alu_zero);
  modport slave  (input alu_a, alu_b, alu_op, output alu_result, alu_slt, alu_zero);
endinterface

// File: rtl/alu_bist_ctrl.sv
// On-chip self-test for the 4-bit ALU: LFSR vector generation, settle wait, golden-model check,
// pass/error/coverage counters and first-failure capture.
module alu_bist_ctrl #(
  parameter int unsigned NUM_TESTS     = 30,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  alu_bist_ctrl_if.master     alu,
  output logic [7:0]          test_count,
  output logic [7:0]          error_count,
  output logic [47:0]         cov_op,
  output logic [7:0]          cov_slt_true,
  output logic [7:0]          cov_slt_false,
  output logic                fail_seen,
  output logic [17:0]         fail_vec
);

  // An all-zero Galois LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS        = 16'hB400;
  localparam logic [7:0]  LAST_TEST   = 8'(NUM_TESTS);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [3:0]  settle_cnt;
  logic [7:0]  cov_cnt [6];

  logic signed [3:0] a_s, b_s;
  logic [3:0]        exp_result;
  logic              slt_cmp, exp_slt, exp_zero, mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic [2:0] fold_op(input logic [2:0] v);
    return (v >= 3'd6) ? v - 3'd6 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
      S_DRIVE:        state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (sat_inc(test_count) == LAST_TEST) ? S_DONE : S_DRIVE;
      default:        state_nxt = S_IDLE;
    endcase
    busy = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
    done = (state == S_DONE);
  end

  assign pass = done && (error_count == 8'd0);

  // Golden model, evaluated on the held operands during CHECK
  always_comb begin
    a_s        = $signed(alu.alu_a);
    b_s        = $signed(alu.alu_b);
    slt_cmp    = (a_s < b_s);
    exp_result = 4'd0;
    case (alu.alu_op)
      3'd0:    exp_result = alu.alu_a + alu.alu_b;
      3'd1:    exp_result = alu.alu_a - alu.alu_b;
      3'd2:    exp_result = alu.alu_a & alu.alu_b;
      3'd3:    exp_result = alu.alu_a | alu.alu_b;
      3'd4:    exp_result = alu.alu_a ^ alu.alu_b;
      3'd5:    exp_result = {3'b000, slt_cmp};
      default: exp_result = 4'd0;
    endcase
    exp_slt  = (alu.alu_op == 3'd5) && slt_cmp;
    exp_zero = (exp_result == 4'd0);
    mismatch = (alu.alu_result != exp_result) || (alu.alu_slt != exp_slt) ||
               (alu.alu_zero != exp_zero);
  end

  assign cov_op = {cov_cnt[5], cov_cnt[4], cov_cnt[3], cov_cnt[2], cov_cnt[1], cov_cnt[0]};

  // Vector generation, settle counting and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr          <= SEED;
      settle_cnt    <= 4'd0;
      alu.alu_a     <= 4'd0;
      alu.alu_b     <= 4'd0;
      alu.alu_op    <= 3'd0;
      test_count    <= 8'd0;
      error_count   <= 8'd0;
      cov_slt_true  <= 8'd0;
      cov_slt_false <= 8'd0;
      fail_seen     <= 1'b0;
      fail_vec      <= 18'd0;
      for (int i = 0; i < 6; i++) cov_cnt[i] <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            test_count    <= 8'd0;
            error_count   <= 8'd0;
            cov_slt_true  <= 8'd0;
            cov_slt_false <= 8'd0;
            fail_seen     <= 1'b0;
            fail_vec      <= 18'd0;
            for (int i = 0; i < 6; i++) cov_cnt[i] <= 8'd0;
          end
        end
        S_DRIVE: begin
          alu.alu_a  <= lfsr[7:4];
          alu.alu_b  <= lfsr[11:8];
          alu.alu_op <= fold_op(lfsr[2:0]);
          lfsr       <= lfsr_step(lfsr);
          settle_cnt <= 4'd0;
        end
        S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        S_CHECK: begin
          test_count <= sat_inc(test_count);
          for (int i = 0; i < 6; i++)
            if (alu.alu_op == 3'(i)) cov_cnt[i] <= sat_inc(cov_cnt[i]);
          if (alu.alu_op == 3'd5) begin
            if (exp_slt) cov_slt_true  <= sat_inc(cov_slt_true);
            else         cov_slt_false <= sat_inc(cov_slt_false);
          end
          if (mismatch) begin
            error_count <= sat_inc(error_count);
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_vec  <= {alu.alu_op, alu.alu_a, alu.alu_b, alu.alu_result,
                            alu.alu_slt, alu.alu_zero, 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: behavioural ALU (optionally faulty) plus a run-level timing/scoreboard model.
module tb_alu_bist_ctrl;
  localparam int N   = 30;
  localparam int S   = 2;
  localparam int TOT = N * (S + 2);

  logic        clk, rst_n, start, fault;
  logic        busy, done, pass, fail_seen;
  logic [7:0]  test_count, error_count, cov_slt_true, cov_slt_false;
  logic [47:0] cov_op;
  logic [17:0] fail_vec;
  logic        start_q, rst_q;

  int n_chk, n_pass;

  alu_bist_ctrl_if bus();

  alu_bist_ctrl #(.NUM_TESTS(N), .SETTLE_CYCLES(S), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .alu(bus), .test_count(test_count), .error_count(error_count), .cov_op(cov_op),
    .cov_slt_true(cov_slt_true), .cov_slt_false(cov_slt_false),
    .fail_seen(fail_seen), .fail_vec(fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    start_q <= start;
    rst_q   <= rst_n;
  end

  // Returns {result[3:0], slt, zero} using plain integer arithmetic
  function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ia, ib, sa, sb, r;
    logic lt;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    lt = (sa < sb);
    r  = 0;
    case (op)
      3'd0: r = (ia + ib) % 16;
      3'd1: r = (ia - ib + 16) % 16;
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = lt ? 1 : 0;
      default: r = 0;
    endcase
    return {4'(r), (op == 3'd5) && lt, r == 0};
  endfunction

  function automatic logic [5:0] alu_out(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op, input logic flt);
    logic [5:0] r;
    r = ref_alu(a, b, op);
    if (flt && op == 3'd5) r[1] = ~r[1];
    return r;
  endfunction

  assign {bus.alu_result, bus.alu_slt, bus.alu_zero} = alu_out(bus.alu_a, bus.alu_b, bus.alu_op, fault);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Run-level model: vector list per run, outputs derived from elapsed cycles since start
  logic [3:0]  va [N];
  logic [3:0]  vb [N];
  logic [2:0]  vop [N];
  logic [15:0] m_lfsr;

  initial begin
    int k, c, d, e_err, st, sf;
    int e_cov [6];
    bit running, run_fault, e_fs, e_busy, e_done;
    logic [3:0] pa, pb, ea, eb;
    logic [2:0] pop, eop;
    logic [5:0] rx, ax;
    logic [17:0] e_fv;
    logic [47:0] e_covp;
    running = 0; run_fault = 0; k = 0; m_lfsr = 16'hACE1;
    pa = 4'd0; pb = 4'd0; pop = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        running = 0; k = 0; m_lfsr = 16'hACE1;
        pa = 4'd0; pb = 4'd0; pop = 3'd0;
      end else if (rst_q) begin
        if (start_q && (!running || k >= TOT)) begin
          if (running) begin
            pa = va[N-1]; pb = vb[N-1]; pop = vop[N-1];
          end
          for (int i = 0; i < N; i++) begin
            va[i]  = m_lfsr[7:4];
            vb[i]  = m_lfsr[11:8];
            vop[i] = 3'(int'(m_lfsr[2:0]) % 6);
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
          end
          running = 1; k = 0; run_fault = fault;
        end else if (running && k < TOT) begin
          k++;
        end
      end
      c = 0; d = 0; e_busy = 0; e_done = 0;
      if (running) begin
        c = k / (S + 2);
        if (c > N) c = N;
        d = (k == 0) ? 0 : (k - 1) / (S + 2) + 1;
        if (d > N) d = N;
        e_busy = (k < TOT);
        e_done = (k >= TOT);
      end
      if (d == 0) begin ea = pa; eb = pb; eop = pop; end
      else begin ea = va[d-1]; eb = vb[d-1]; eop = vop[d-1]; end
      e_err = 0; st = 0; sf = 0; e_fs = 0; e_fv = 18'd0;
      for (int i = 0; i < 6; i++) e_cov[i] = 0;
      for (int i = 0; i < c; i++) begin
        rx = ref_alu(va[i], vb[i], vop[i]);
        ax = alu_out(va[i], vb[i], vop[i], run_fault);
        e_cov[vop[i]]++;
        if (vop[i] == 3'd5) begin
          if (rx[1]) st++; else sf++;
        end
        if (rx != ax) begin
          e_err++;
          if (!e_fs) begin
            e_fs = 1;
            e_fv = {vop[i], va[i], vb[i], ax[5:2], ax[1], ax[0], 1'b0};
          end
        end
      end
      for (int i = 0; i < 6; i++) e_covp[i*8 +: 8] = 8'(e_cov[i]);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("pass", pass, e_done && e_err == 0);
      chk("alu_a", bus.alu_a, ea);
      chk("alu_b", bus.alu_b, eb);
      chk("alu_op", bus.alu_op, eop);
      chk("test_count", test_count, c);
      chk("error_count", error_count, e_err);
      chk("cov_op", cov_op, e_covp);
      chk("cov_slt_true", cov_slt_true, st);
      chk("cov_slt_false", cov_slt_false, sf);
      chk("fail_seen", fail_seen, e_fs);
      chk("fail_vec", fail_vec, e_fv);
    end
  end

  task automatic do_run(input bit lit_vecs, input bit pulse_busy, input bit expect_new, output int lat);
    bit seen;
    @(posedge clk); #1 start = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (pulse_busy && (lat == 20 || lat == 60)) start = 1'b1;
      if (pulse_busy && (lat == 21 || lat == 61)) start = 1'b0;
      if (expect_new && lat == 1) chk("restart_clears", test_count, 0);
      if (expect_new && lat == 3)
        chk("run2_vec1_new", {bus.alu_a, bus.alu_b, bus.alu_op} != {4'hE, 4'hC, 3'd1}, 1);
      if (lit_vecs && lat == 3) begin
        chk("vec1_a", bus.alu_a, 4'hE);
        chk("vec1_b", bus.alu_b, 4'hC);
        chk("vec1_op", bus.alu_op, 3'd1);
        chk("vec1_result", bus.alu_result, 4'h2);
      end
      if (lit_vecs && lat == 7) begin
        chk("vec2_a", bus.alu_a, 4'h7);
        chk("vec2_b", bus.alu_b, 4'h2);
        chk("vec2_op", bus.alu_op, 3'd0);
        chk("vec2_result", bus.alu_result, 4'h9);
      end
      seen = done;
    end
    chk("done_latency", lat, 121);
  endtask

  initial begin
    int lat, s;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; fault = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_test_count", test_count, 0);
    chk("idle_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);

    do_run(1'b1, 1'b0, 1'b0, lat);
    chk("run1_test_count", test_count, 30);
    chk("run1_error_count", error_count, 0);
    chk("run1_pass", pass, 1);
    chk("run1_fail_seen", fail_seen, 0);
    s = 0;
    for (int i = 0; i < 6; i++) s += int'(cov_op[i*8 +: 8]);
    chk("run1_cov_sum", s, 30);
    chk("run1_slt_split", cov_slt_true + cov_slt_false, cov_op[47:40]);

    repeat (3) @(posedge clk);
    do_run(1'b0, 1'b1, 1'b1, lat);
    chk("run2_test_count", test_count, 30);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (38) @(posedge clk);
    #2;
    chk("pre_reset_test_count", test_count, 9);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_test_count", test_count, 0);
    chk("async_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    chk("async_cov_op", cov_op, 0);
    fault = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    do_run(1'b1, 1'b0, 1'b0, lat);
    chk("fault_err_eq_slt", error_count, cov_op[47:40]);
    chk("fault_fail_seen", fail_seen, 1);
    chk("fault_fail_op", fail_vec[17:15], 3'b101);
    chk("fault_fail_vec", fail_vec, 18'h2E708);
    chk("fault_pass", pass, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
